i2c_slave_regs: RTL and testbench

- I2C slave endpoint downstream of the Master block, on the same Scl/Sda bus.
- Decodes START/STOP, matches a 7-bit address, and latches a pointer byte.
- Services pointer-addressed 16-bit registers: reg0 is a read-only sensor value; regs 1-3 are read/write configuration.
- Oversamples Scl/Sda on its own system clock; Sda is open-drain (drives 0 or releases to z).

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_line_sync.sv | 34 +++
 rtl/i2c_slave_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM encoding, register
// indices and reset defaults.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_MSB,
    ST_WR_MSB_ACK,
    ST_WR_LSB,
    ST_WR_LSB_ACK,
    ST_RD_MSB,
    ST_RD_MSB_ACK,
    ST_RD_LSB,
    ST_RD_LSB_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic [1:0] REG_SENSOR = 2'd0;
  localparam logic [1:0] REG1       = 2'd1;
  localparam logic [1:0] REG2       = 2'd2;
  localparam logic [1:0] REG3       = 2'd3;

  localparam logic [6:0]  DEF_SLAVE_ADR = 7'b1001000;
  localparam logic [15:0] DEF_RST_REG1  = 16'h0000;
  localparam logic [15:0] DEF_RST_REG2  = 16'h4B00;
  localparam logic [15:0] DEF_RST_REG3  = 16'h5000;

  // Minimum Scl phase in Clk cycles that the sampling scheme tolerates.
  localparam int SCL_MIN_PHASE = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers on Scl/Sda plus edge and START/STOP pulses,
// all derived from the synchronised samples.
module i2c_line_sync (
  input  logic Clk,
  input  logic Rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0],[1] synchronise; [2] is the previous synchronised sample
  logic [2:0] r_scl, r_sda;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise =  r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] &  r_scl[2];
  assign o_start    =  r_scl[1] &  r_scl[2] &  r_sda[2] & ~r_sda[1];
  assign o_stop     =  r_scl[1] &  r_scl[2] & ~r_sda[2] &  r_sda[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave with a pointer byte selecting one of four 16-bit registers:
// reg0 mirrors Sensor (read-only), reg1-3 are read/write configuration.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADR = DEF_SLAVE_ADR,
  parameter logic [15:0] RST_REG1  = DEF_RST_REG1,
  parameter logic [15:0] RST_REG2  = DEF_RST_REG2,
  parameter logic [15:0] RST_REG3  = DEF_RST_REG3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Scl,
  inout  wire         Sda,
  input  logic [15:0] Sensor,
  output logic [15:0] Reg1,
  output logic [15:0] Reg2,
  output logic [15:0] Reg3,
  output logic        Wr_strobe,
  output logic [1:0]  Wr_idx,
  output logic        Busy
);

  logic w_sda, w_rise, w_fall, w_start, w_stop;

  i2c_line_sync u_sync (
    .Clk(Clk), .Rst(Rst), .i_scl(Scl), .i_sda(Sda),
    .o_sda(w_sda), .o_scl_rise(w_rise), .o_scl_fall(w_fall),
    .o_start(w_start), .o_stop(w_stop)
  );

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        r_full, w_full_nxt;
  logic [7:0]  r_rx, w_rx_nxt, r_tx, w_tx_nxt, r_hold, w_hold_nxt;
  logic [15:0] r_snap, w_snap_nxt, w_rd_val;
  logic [1:0]  r_ptr, w_ptr_nxt;
  logic        r_rw, w_rw_nxt, r_nack, w_nack_nxt;
  logic        r_oe, w_oe_nxt, r_busy, w_busy_nxt, w_commit;
  logic [15:0] r_reg1, r_reg2, r_reg3;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_idx;

  assign Sda = r_oe ? 1'b0 : 1'bz;

  always_comb begin
    case (r_ptr)
      REG1:    w_rd_val = r_reg1;
      REG2:    w_rd_val = r_reg2;
      REG3:    w_rd_val = r_reg3;
      default: w_rd_val = Sensor;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_full_nxt  = r_full;
    w_rx_nxt    = r_rx;
    w_tx_nxt    = r_tx;
    w_hold_nxt  = r_hold;
    w_snap_nxt  = r_snap;
    w_ptr_nxt   = r_ptr;
    w_rw_nxt    = r_rw;
    w_nack_nxt  = r_nack;
    w_oe_nxt    = r_oe;
    w_busy_nxt  = r_busy;
    w_commit    = 1'b0;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_full_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
      w_cnt_nxt   = '0;
      w_full_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
    end else if (w_rise) begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WR_MSB, ST_WR_LSB, ST_RD_MSB, ST_RD_LSB, ST_WAIT_STOP: begin
          w_rx_nxt  = {r_rx[6:0], w_sda};
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_full_nxt = 1'b1;
        end
        ST_RD_MSB_ACK, ST_RD_LSB_ACK: w_nack_nxt = w_sda;
        default: ;
      endcase
    end else if (w_fall) begin
      // Byte decisions happen on the fall closing bit 8, so the ACK drive
      // lands in the low phase before the 9th clock.
      case (r_state)
        ST_ADDR: if (r_full) begin
          w_full_nxt = 1'b0;
          if (r_rx[7:1] == SLAVE_ADR) begin
            w_rw_nxt    = r_rx[0];
            w_oe_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_ADDR_ACK;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_WAIT_STOP;
          end
        end
        ST_ADDR_ACK: if (r_rw) begin
          w_snap_nxt  = w_rd_val;
          w_tx_nxt    = w_rd_val[15:8];
          w_oe_nxt    = ~w_rd_val[15];
          w_state_nxt = ST_RD_MSB;
        end else begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_PTR;
        end
        ST_PTR: if (r_full) begin
          w_full_nxt = 1'b0;
          if (r_rx[7:2] == 6'd0) begin
            w_ptr_nxt   = r_rx[1:0];
            w_oe_nxt    = 1'b1;
            w_state_nxt = ST_PTR_ACK;
          end else begin
            w_state_nxt = ST_WAIT_STOP;
          end
        end
        ST_PTR_ACK: begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_WR_MSB;
        end
        ST_WR_MSB: if (r_full) begin
          w_full_nxt  = 1'b0;
          w_hold_nxt  = r_rx;
          w_oe_nxt    = 1'b1;
          w_state_nxt = ST_WR_MSB_ACK;
        end
        ST_WR_MSB_ACK: begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_WR_LSB;
        end
        ST_WR_LSB: if (r_full) begin
          w_full_nxt  = 1'b0;
          w_oe_nxt    = 1'b1;
          w_state_nxt = ST_WR_LSB_ACK;
        end
        ST_WR_LSB_ACK: begin
          w_commit    = 1'b1;
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_WAIT_STOP;
        end
        ST_RD_MSB, ST_RD_LSB: if (r_full) begin
          w_full_nxt  = 1'b0;
          w_oe_nxt    = 1'b0;
          w_state_nxt = (r_state == ST_RD_MSB) ? ST_RD_MSB_ACK : ST_RD_LSB_ACK;
        end else begin
          w_tx_nxt = {r_tx[6:0], 1'b0};
          w_oe_nxt = ~r_tx[6];
        end
        ST_RD_MSB_ACK, ST_RD_LSB_ACK: if (r_nack) begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = ST_WAIT_STOP;
        end else if (r_state == ST_RD_MSB_ACK) begin
          w_tx_nxt    = r_snap[7:0];
          w_oe_nxt    = ~r_snap[7];
          w_state_nxt = ST_RD_LSB;
        end else begin
          w_tx_nxt    = r_snap[15:8];
          w_oe_nxt    = ~r_snap[15];
          w_state_nxt = ST_RD_MSB;
        end
        ST_WAIT_STOP: w_full_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_hold      <= '0;
      r_snap      <= '0;
      r_ptr       <= REG_SENSOR;
      r_rw        <= 1'b0;
      r_nack      <= 1'b1;
      r_oe        <= 1'b0;
      r_busy      <= 1'b0;
      r_reg1      <= RST_REG1;
      r_reg2      <= RST_REG2;
      r_reg3      <= RST_REG3;
      r_wr_strobe <= 1'b0;
      r_wr_idx    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_full      <= w_full_nxt;
      r_rx        <= w_rx_nxt;
      r_tx        <= w_tx_nxt;
      r_hold      <= w_hold_nxt;
      r_snap      <= w_snap_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_nack      <= w_nack_nxt;
      r_oe        <= w_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= 1'b0;
      // Pointer 0 writes are acknowledged on the bus but dropped here.
      if (w_commit && r_ptr != REG_SENSOR) begin
        r_wr_strobe <= 1'b1;
        r_wr_idx    <= r_ptr;
        case (r_ptr)
          REG1:    r_reg1 <= {r_hold, r_rx};
          REG2:    r_reg2 <= {r_hold, r_rx};
          default: r_reg3 <= {r_hold, r_rx};
        endcase
      end
    end
  end

  assign Reg1      = r_reg1;
  assign Reg2      = r_reg2;
  assign Reg3      = r_reg3;
  assign Wr_strobe = r_wr_strobe;
  assign Wr_idx    = r_wr_idx;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged I2C master, directed scenarios and
// random transactions against a transaction-level register model.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [15:0] Sensor = 16'h0000;
  wire         sda_bus;
  wire  [15:0] Reg1, Reg2, Reg3;
  wire         Wr_strobe, Busy;
  wire  [1:0]  Wr_idx;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  i2c_slave_regs dut (
    .Clk(Clk), .Rst(Rst), .Scl(Scl), .Sda(sda_bus), .Sensor(Sensor),
    .Reg1(Reg1), .Reg2(Reg2), .Reg3(Reg3),
    .Wr_strobe(Wr_strobe), .Wr_idx(Wr_idx), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;
  int strobe_cnt = 0, drv_cnt = 0;
  logic [1:0] last_idx = 2'd0;

  always @(negedge Clk) begin
    if (Wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_idx = Wr_idx;
    end
    if (sda_bus === 1'b0 && m_sda) drv_cnt++;
  end

  // reference model: register file, pointer
  logic [15:0] m_reg [0:3];
  logic [1:0]  m_ptr;

  function automatic logic [15:0] mval(input logic [1:0] p);
    return (p == 2'd0) ? Sensor : m_reg[p];
  endfunction

  task automatic model_reset();
    m_reg[0] = 16'h0; m_reg[1] = 16'h0000; m_reg[2] = 16'h4B00; m_reg[3] = 16'h5000;
    m_ptr = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wt(4); Scl = 1'b1; wt(8); m_sda = 1'b0; wt(8); Scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wt(4); m_sda = 1'b0; wt(4); Scl = 1'b1; wt(8); m_sda = 1'b1; wt(8);
  endtask

  task automatic wbits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wt(4); m_sda = b[7-i]; wt(4); Scl = 1'b1; wt(8); Scl = 1'b0;
    end
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    wbits(b, 8);
    wt(4); m_sda = 1'b1; wt(4); Scl = 1'b1; wt(4); ack = ~sda_bus; wt(4); Scl = 1'b0;
  endtask

  task automatic rbyte(output logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      wt(8); Scl = 1'b1; wt(4); b[i] = sda_bus; wt(4); Scl = 1'b0;
    end
    wt(4); m_sda = ~mack; wt(4); Scl = 1'b1; wt(8); Scl = 1'b0; wt(2); m_sda = 1'b1;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_reg1"}, 32'(Reg1), 32'(m_reg[1]));
    chk({tag, "_reg2"}, 32'(Reg2), 32'(m_reg[2]));
    chk({tag, "_reg3"}, 32'(Reg3), 32'(m_reg[3]));
  endtask

  task automatic txn_write(input logic [7:0] p, input logic [15:0] d);
    logic a, pok;
    int s0;
    s0 = strobe_cnt;
    pok = (p < 8'd4);
    i2c_start();
    wbyte(8'h90, a);      chk("w_adr_ack", 32'(a), 32'd1);
    chk("w_busy", 32'(Busy), 32'd1);
    wbyte(p, a);          chk("w_ptr_ack", 32'(a), 32'(pok));
    if (pok) m_ptr = p[1:0];
    wbyte(d[15:8], a);    chk("w_msb_ack", 32'(a), 32'(pok));
    wbyte(d[7:0], a);     chk("w_lsb_ack", 32'(a), 32'(pok));
    i2c_stop();
    if (pok && p != 8'd0) begin
      m_reg[p[1:0]] = d;
      chk("w_strobes", 32'(strobe_cnt - s0), 32'd1);
      chk("w_idx", 32'(last_idx), 32'(p));
    end else begin
      chk("w_strobes", 32'(strobe_cnt - s0), 32'd0);
    end
    chk("w_busy_end", 32'(Busy), 32'd0);
    check_regs("w");
  endtask

  task automatic txn_read(input logic setp, input logic [1:0] p, input int n);
    logic a;
    logic [7:0] b;
    logic [15:0] v;
    if (setp) begin
      i2c_start();
      wbyte(8'h90, a);   chk("r_adr_w_ack", 32'(a), 32'd1);
      wbyte({6'd0, p}, a); chk("r_ptr_ack", 32'(a), 32'd1);
      m_ptr = p;
    end
    i2c_start();
    wbyte(8'h91, a);     chk("r_adr_ack", 32'(a), 32'd1);
    chk("r_busy", 32'(Busy), 32'd1);
    v = mval(m_ptr);
    for (int k = 0; k < n; k++) begin
      rbyte(b, k != n - 1);
      chk("rd_byte", 32'(b), (k % 2 == 0) ? 32'(v[15:8]) : 32'(v[7:0]));
    end
    i2c_stop();
    chk("r_busy_end", 32'(Busy), 32'd0);
    check_regs("r");
  endtask

  task automatic txn_mismatch(input logic [7:0] adr);
    logic a;
    int d0, s0;
    d0 = drv_cnt; s0 = strobe_cnt;
    i2c_start();
    wbyte(adr, a);                   chk("mm_adr_nack", 32'(a), 32'd0);
    chk("mm_busy", 32'(Busy), 32'd0);
    wbyte(8'($urandom_range(0, 255)), a); chk("mm_data_nack", 32'(a), 32'd0);
    i2c_stop();
    chk("mm_no_drive", 32'(drv_cnt - d0), 32'd0);
    chk("mm_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check_regs("mm");
  endtask

  initial begin
    logic a;
    int s0, kind;
    logic [6:0] a7;
    model_reset();
    wt(5);
    chk("rst_reg1", 32'(Reg1), 32'h0000);
    chk("rst_reg2", 32'(Reg2), 32'h4B00);
    chk("rst_reg3", 32'(Reg3), 32'h5000);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_strobe", 32'(Wr_strobe), 32'd0);
    chk("rst_idx", 32'(Wr_idx), 32'd0);
    chk("rst_sda", 32'(sda_bus), 32'd1);
    Rst = 1'b1;
    wt(SCL_MIN_PHASE * 4);

    txn_write(8'h02, 16'h1234);
    txn_write(8'h05, 16'hDEAD);
    chk("badptr_kept", 32'(m_ptr), 32'd2);
    txn_read(1'b0, 2'd0, 2);
    Sensor = 16'hABCD;
    txn_read(1'b1, 2'd0, 2);
    txn_mismatch(8'h92);

    // write to reg3 aborted by STOP mid-LSB
    s0 = strobe_cnt;
    i2c_start();
    wbyte(8'h90, a); chk("ab_adr_ack", 32'(a), 32'd1);
    wbyte(8'h03, a); chk("ab_ptr_ack", 32'(a), 32'd1);
    m_ptr = 2'd3;
    wbyte(8'hAA, a); chk("ab_msb_ack", 32'(a), 32'd1);
    wbits(8'h56, 4);
    i2c_stop();
    chk("ab_reg3", 32'(Reg3), 32'h5000);
    chk("ab_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("ab_busy", 32'(Busy), 32'd0);

    txn_write(8'h01, 16'hBEEF);
    txn_read(1'b1, 2'd1, 3);
    txn_write(8'h00, 16'h7777);

    // reset while the slave is driving a 0 data bit
    Sensor = 16'h1234;
    i2c_start();
    wbyte(8'h91, a); chk("rr_adr_ack", 32'(a), 32'd1);
    wt(6);
    chk("rr_driving", 32'(sda_bus), 32'd0);
    Rst = 1'b0;
    #1;
    chk("rr_released", 32'(sda_bus), 32'd1);
    wt(2);
    model_reset();
    check_regs("rr");
    chk("rr_busy", 32'(Busy), 32'd0);
    Rst = 1'b1;
    wt(4); Scl = 1'b1; wt(16);

    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      Sensor = 16'($urandom);
      case (kind)
        0: txn_write(8'($urandom_range(0, 7)), 16'($urandom));
        1: txn_read(1'b1, 2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
        2: txn_read(1'b0, 2'd0, int'($urandom_range(1, 4)));
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h48) a7 = 7'h49;
          txn_mismatch({a7, 1'($urandom_range(0, 1))});
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
